// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared types and sizes for the HI/LO multiply controller and the multiplier
// it drives.
package mul_pkg;

   localparam int MUL_W       = 16;
   localparam int PROD_W      = 32;
   localparam int TIMEOUT_DEF = 48;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      CORR
   } state_t;

endpackage

// File: rtl/mul_hilo_ctrl_if.sv
// Bus between the HI/LO controller (master) and the sequential shift-add
// multiplier (slave).
interface mul_hilo_ctrl_if;
   import mul_pkg::*;

   logic              Mul_St;
   logic [MUL_W-1:0]  Mul_A;
   logic [MUL_W-1:0]  Mul_B;
   logic              Mul_Idle;
   logic              Mul_Done;
   logic [PROD_W-1:0] Mul_Produto;

   modport master (
      output Mul_St,
      output Mul_A,
      output Mul_B,
      input  Mul_Idle,
      input  Mul_Done,
      input  Mul_Produto
   );

   modport slave (
      input  Mul_St,
      input  Mul_A,
      input  Mul_B,
      output Mul_Idle,
      output Mul_Done,
      output Mul_Produto
   );

endinterface

// File: rtl/mul_hilo_ctrl_sign_cond.sv
// Sign conditioning around an unsigned multiplier: operand magnitudes, result
// sign, and the final two's-complement correction of the product.
module mul_sign_cond
   import mul_pkg::*;
(
   input  logic              sign_en,
   input  logic [MUL_W-1:0]  op_a,
   input  logic [MUL_W-1:0]  op_b,
   input  logic              neg,
   input  logic [PROD_W-1:0] prod,
   output logic [MUL_W-1:0]  mag_a,
   output logic [MUL_W-1:0]  mag_b,
   output logic              neg_req,
   output logic [PROD_W-1:0] prod_fix
);

   // 0x8000 negates to itself, which is the correct unsigned magnitude.
   assign mag_a    = (sign_en && op_a[MUL_W-1]) ? -op_a : op_a;
   assign mag_b    = (sign_en && op_b[MUL_W-1]) ? -op_b : op_b;
   assign neg_req  = sign_en & (op_a[MUL_W-1] ^ op_b[MUL_W-1]);
   assign prod_fix = neg ? -prod : prod;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Issue/writeback controller: launches the shift-add multiplier, restores the
// product sign, and owns the architectural HI/LO registers.
module mul_hilo_ctrl
   import mul_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
)
(
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Req,
   input  logic             Signed,
   input  logic [MUL_W-1:0] OpA,
   input  logic [MUL_W-1:0] OpB,
   input  logic             Wr_Hi,
   input  logic             Wr_Lo,
   input  logic [MUL_W-1:0] Wr_Data,
   mul_hilo_ctrl_if.master  mul,
   output logic [MUL_W-1:0] Hi,
   output logic [MUL_W-1:0] Lo,
   output logic             Busy,
   output logic             Valid,
   output logic             Err
);

   localparam int CNT_W = $clog2(TIMEOUT);

   state_t            state;
   state_t            next_state;
   logic [CNT_W-1:0]  cnt;
   logic              neg;
   logic [PROD_W-1:0] prod;
   logic [MUL_W-1:0]  mag_a;
   logic [MUL_W-1:0]  mag_b;
   logic              neg_req;
   logic [PROD_W-1:0] prod_fix;
   logic              timeout_hit;

   mul_sign_cond u_sign (
      .sign_en  (Signed),
      .op_a     (OpA),
      .op_b     (OpB),
      .neg      (neg),
      .prod     (prod),
      .mag_a    (mag_a),
      .mag_b    (mag_b),
      .neg_req  (neg_req),
      .prod_fix (prod_fix)
   );

   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
   assign Busy        = (state != IDLE);

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Mul_St waits for Mul_Idle so a multiplier still running after a reset is
   // allowed to drain before the next launch.
   always_comb begin
      next_state = state;
      mul.Mul_St = 1'b0;
      Valid      = 1'b0;
      case (state)
         IDLE: begin
            if (Req) begin
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            if (mul.Mul_Idle) begin
               mul.Mul_St = 1'b1;
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (mul.Mul_Done) begin
               next_state = CORR;
            end else if (timeout_hit) begin
               next_state = IDLE;
            end
         end
         CORR: begin
            Valid      = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // A write issued together with Req lands first and is overwritten at CORR.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         Hi        <= '0;
         Lo        <= '0;
         mul.Mul_A <= '0;
         mul.Mul_B <= '0;
         neg       <= 1'b0;
         Err       <= 1'b0;
         cnt       <= '0;
         prod      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Wr_Hi) begin
                  Hi <= Wr_Data;
               end
               if (Wr_Lo) begin
                  Lo <= Wr_Data;
               end
               if (Req) begin
                  mul.Mul_A <= mag_a;
                  mul.Mul_B <= mag_b;
                  neg       <= neg_req;
                  Err       <= 1'b0;
               end
            end
            ISSUE: begin
               if (mul.Mul_Idle) begin
                  cnt <= '0;
               end
            end
            WAIT: begin
               if (mul.Mul_Done) begin
                  prod <= mul.Mul_Produto;
               end else if (timeout_hit) begin
                  Err <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CORR: begin
               {Hi, Lo} <= prod_fix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Issue and writeback controller for the 16x16 sequential shift-add multiplier. It accepts a MULT/MULTU request from the CPU pipeline, conditions signed operands to magnitudes, and launches the multiplier with a one-cycle `St` pulse. It then waits for `Done`, restores the product sign, and commits the 32-bit result into architectural HI/LO registers. It also serves MTHI/MTLO writes and drives `Busy`, which the pipeline uses to stall while a multiply is in flight.

## Interface
- `TIMEOUT`, 48: cycles allowed in WAIT before the operation is aborted.
- `Clk`  in  1  system clock, all state on rising edge.
- `Rst_n`  in  1  reset, synchronous, active-low.
- `Req`  in  1  start multiply; sampled only in IDLE.
- `Signed`  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with `Req`.
- `OpA`, `OpB`  in  16 each  operands; sampled with `Req`.
- `Wr_Hi`, `Wr_Lo`  in  1 each  MTHI/MTLO strobes; honoured only in IDLE.
- `Wr_Data`  in  16  data for MTHI/MTLO.
- `Mul_St`  out  1  start pulse to the multiplier.
- `Mul_A`, `Mul_B`  out  16 each  registered operand magnitudes (multiplicand, multiplier).
- `Mul_Idle`, `Mul_Done`  in  1 each  multiplier status.
- `Mul_Produto`  in  32  unsigned product from the multiplier.
- `Hi`, `Lo`  out  16 each  architectural HI = product[31:16], LO = product[15:0].
- `Busy`  out  1  high in every state except IDLE.
- `Valid`  out  1  one-cycle pulse when HI/LO are committed from a multiply.
- `Err`  out  1  sticky timeout flag; cleared on the next accepted `Req`.

## Operation
- Reset values: state IDLE; `Hi`, `Lo`, `Mul_A`, `Mul_B` = 0; `Mul_St`, `Valid`, `Err` = 0; `Busy` = 0; `Neg` and the watchdog counter = 0.
- IDLE
  - On `Req`: latch `Mul_A`/`Mul_B` = |OpA|/|OpB| if `Signed`, else raw.
  - Latch `Neg` = Signed & (OpA[15] ^ OpB[15]).
  - Clear `Err` and go to ISSUE.
- ISSUE: if `Mul_Idle`=1, assert `Mul_St` for exactly this cycle, clear the counter, go to WAIT. Otherwise hold without `St`.
- WAIT
  - Count cycles.
  - On `Mul_Done`=1: register `Mul_Produto` into an internal product register, go to CORR.
  - If the count reaches `TIMEOUT` first: set `Err`, go to IDLE, leave HI/LO unchanged.
- CORR: HI:LO <= Neg ? (~P + 1) : P (32-bit two's complement), pulse `Valid`, go to IDLE.
- Width rules:
  - |-32768| = 0x8000, which fits as an unsigned magnitude.
  - Maximum magnitude product is 0x40000000, so negation never overflows.
- MTHI/MTLO in IDLE: write the selected register next edge. Both strobes together write both registers.
- Simultaneous `Req` and `Wr_*` in IDLE: the write commits, then the multiply result overwrites it at CORR.
- `Wr_*` while `Busy`: ignored. `Req` while `Busy`: ignored.
- `Mul_Done` outside WAIT is ignored (stale or unsolicited).
- Reset mid-operation returns to IDLE with reset values. A still-running multiplier is absorbed because ISSUE waits for `Mul_Idle`.

## Timing
- Cycle 0: `Req` sampled in IDLE; `Busy` high from cycle 1.
- Cycle 1: ISSUE, `Mul_St`=1, provided `Mul_Idle`=1.
- Cycle d: `Mul_Done` seen in WAIT.
- Cycle d+1: CORR, `Valid`=1.
- Cycle d+2: new `Hi`/`Lo` visible, `Busy`=0, next `Req` accepted.
- Total latency `Req` to `Valid` = multiplier latency + 2 cycles.
- Timeout: `Err` is visible TIMEOUT+2 cycles after `Req` when `Mul_Done` never rises.

## Structure
- Shared package `mul_pkg`:
  - state enum (IDLE, ISSUE, WAIT, CORR);
  - `MUL_W`=16 and `PROD_W`=32;
  - default `TIMEOUT`.
- One sub-module, `mul_sign_cond`: combinational abs of both operands, negate flag, and conditional 32-bit negate of the product. It is instantiated once and used at IDLE latch and in CORR.
- FSM, watchdog counter, and HI/LO registers live in the top module.

## Test plan
- MULTU 3 x 5, behavioural multiplier with 17-cycle latency -> `Hi`=0x0000, `Lo`=0x000F; `Valid` exactly once, 19 cycles after `Req`.
- MULT -3 (0xFFFD) x 5 -> `Mul_A`=3, `Mul_B`=5; `Hi`=0xFFFF, `Lo`=0xFFF1.
- MULT 0x8000 x 0x8000 -> `Hi`=0x4000, `Lo`=0x0000. MULTU 0xFFFF x 0xFFFF -> `Hi`=0xFFFE, `Lo`=0x0001.
- `Mul_Idle` held low for 5 cycles after `Req` -> `Mul_St` held off, then a single 1-cycle pulse; a spurious `Mul_Done` in IDLE does not change HI/LO.
- `Mul_Done` never asserted -> `Err`=1 TIMEOUT+2 cycles after `Req`, HI/LO unchanged, `Busy`=0. Next `Req` clears `Err`.
- MTHI 0x1234 then MTLO 0xABCD in IDLE -> `Hi`=0x1234, `Lo`=0xABCD. `Wr_Lo` during `Busy` is ignored. `Rst_n`=0 in WAIT -> all outputs at reset values on the next edge.
